// File: rtl/selfcomp_lockstep_checker.sv
// selfcomp_lockstep_checker
//   Watches NCOPY lock-stepped copies of a functional unit that share one
//   launch strobe. Each launch opens a WAIT window; every copy's first ready
//   captures its result. At the end of the window a one-cycle verdict reports
//   data divergence against copy 0 and timing divergence (ready skew or a copy
//   that never answered before TIMEOUT). Sticky flags and saturating counters
//   accumulate over many transactions.
//
// Ports
//   g_clk, g_reset        clock, synchronous active-high reset
//   valid                 launch strobe (ignored while busy)
//   clear                 zero counters and sticky flags
//   lane_ready/lane_rd    per-copy ready and result (copy i at [i*XLEN +: XLEN])
//   busy                  transaction in flight
//   done                  one-cycle verdict strobe
//   data_fail, timing_fail, timeout, mismatch_mask, missing_mask
//                         verdict, held until the next done
//   stray_ready           sticky: ready seen while idle
//   err_sticky            sticky: some verdict failed
//   txn_count, err_count  saturating completed / failed transaction counts

// Per-copy result capture. The next-state value is exported so the verdict
// can include a result captured in the final WAIT cycle.
module selfcomp_lane #(
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            cap_en_i,
  input  logic [XLEN-1:0] rd_i,
  output logic [XLEN-1:0] cap_d_o
);
  logic [XLEN-1:0] cap_q;

  assign cap_d_o = cap_en_i ? rd_i : cap_q;

  always_ff @(posedge g_clk) begin
    if (g_reset) cap_q <= '0;
    else         cap_q <= cap_d_o;
  end
endmodule

module selfcomp_lockstep_checker #(
  parameter int NCOPY   = 2,
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  valid,
  input  logic                  clear,
  input  logic [NCOPY-1:0]      lane_ready,
  input  logic [NCOPY*XLEN-1:0] lane_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  data_fail,
  output logic                  timing_fail,
  output logic                  timeout,
  output logic [NCOPY-1:0]      mismatch_mask,
  output logic [NCOPY-1:0]      missing_mask,
  output logic                  stray_ready,
  output logic                  err_sticky,
  output logic [CNTW-1:0]       txn_count,
  output logic [CNTW-1:0]       err_count
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                       state_q, state_d;
  logic   [NCOPY-1:0]           seen_q, seen_d;
  logic                         skew_q, skew_d;
  logic   [WW-1:0]              wcnt_q, wcnt_d;
  logic                         exit_w;
  logic   [NCOPY-1:0]           newr, cap_en, mm_next;
  logic   [NCOPY-1:0][XLEN-1:0] cap_d;

  logic                         done_q, df_q, tf_q, to_q, stray_q, sticky_q;
  logic                         done_d, df_d, tf_d, to_d, stray_d, sticky_d;
  logic   [NCOPY-1:0]           mm_q, mm_d, miss_q, miss_d;
  logic   [CNTW-1:0]            txn_q, txn_d, err_q, err_d;
  logic   [CNTW-1:0]            txn_base, err_base;

  // First ready of a copy during WAIT; repeats are ignored.
  assign newr   = lane_ready & ~seen_q;
  assign cap_en = (state_q == WAIT) ? newr : '0;

  for (genvar i = 0; i < NCOPY; i++) begin : g_lane
    selfcomp_lane #(.XLEN(XLEN)) u_lane (
      .g_clk    (g_clk),
      .g_reset  (g_reset),
      .cap_en_i (cap_en[i]),
      .rd_i     (lane_rd[i*XLEN +: XLEN]),
      .cap_d_o  (cap_d[i])
    );
  end

  // A copy is compared only when both it and copy 0 produced a result.
  always_comb begin
    mm_next = '0;
    for (int i = 1; i < NCOPY; i++)
      mm_next[i] = seen_d[i] & seen_d[0] & (cap_d[i] != cap_d[0]);
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    skew_d  = skew_q;
    wcnt_d  = wcnt_q;
    exit_w  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = WAIT;
          seen_d  = '0;
          skew_d  = 1'b0;
          wcnt_d  = WW'(1);
        end
      end
      WAIT: begin
        seen_d = seen_q | lane_ready;
        // New arrivals while someone is still outstanding means the copies
        // did not all answer in the same cycle.
        if ((|newr) && !(&seen_d)) skew_d = 1'b1;
        if ((&seen_d) || (wcnt_q == WW'(TIMEOUT))) begin
          exit_w  = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Verdict registers load on the exit edge and hold until the next one.
  always_comb begin
    done_d = exit_w;
    mm_d   = mm_q;
    miss_d = miss_q;
    df_d   = df_q;
    to_d   = to_q;
    tf_d   = tf_q;
    if (exit_w) begin
      mm_d   = mm_next;
      miss_d = ~seen_d;
      df_d   = |mm_next;
      to_d   = |(~seen_d);
      tf_d   = skew_d | (|(~seen_d));
    end
  end

  // Bookkeeping follows the done cycle so a coincident clear lands first.
  always_comb begin
    txn_base = clear ? '0 : txn_q;
    err_base = clear ? '0 : err_q;
    txn_d    = txn_base;
    err_d    = err_base;
    if (done_q && (txn_base != {CNTW{1'b1}})) txn_d = txn_base + CNTW'(1);
    if (done_q && (df_q | tf_q) && (err_base != {CNTW{1'b1}}))
      err_d = err_base + CNTW'(1);
    sticky_d = (clear ? 1'b0 : sticky_q) | (done_q & (df_q | tf_q));
    stray_d  = (clear ? 1'b0 : stray_q) | ((state_q == IDLE) & (|lane_ready));
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= IDLE;
      seen_q   <= '0;
      skew_q   <= 1'b0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      df_q     <= 1'b0;
      tf_q     <= 1'b0;
      to_q     <= 1'b0;
      mm_q     <= '0;
      miss_q   <= '0;
      stray_q  <= 1'b0;
      sticky_q <= 1'b0;
      txn_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      skew_q   <= skew_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      df_q     <= df_d;
      tf_q     <= tf_d;
      to_q     <= to_d;
      mm_q     <= mm_d;
      miss_q   <= miss_d;
      stray_q  <= stray_d;
      sticky_q <= sticky_d;
      txn_q    <= txn_d;
      err_q    <= err_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign data_fail     = df_q;
  assign timing_fail   = tf_q;
  assign timeout       = to_q;
  assign mismatch_mask = mm_q;
  assign missing_mask  = miss_q;
  assign stray_ready   = stray_q;
  assign err_sticky    = sticky_q;
  assign txn_count     = txn_q;
  assign err_count     = err_q;
endmodule

// File: tb/tb_selfcomp_lockstep_checker.sv
module tb_selfcomp_lockstep_checker;
  localparam int NC = 4;
  localparam int XL = 64;
  localparam int TO = 4;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic             g_clk = 1'b0;
  logic             g_reset, valid, clear;
  logic [NC-1:0]    lane_ready;
  logic [NC*XL-1:0] lane_rd;
  logic             busy, done, data_fail, timing_fail, timeout;
  logic [NC-1:0]    mismatch_mask, missing_mask;
  logic             stray_ready, err_sticky;
  logic [CW-1:0]    txn_count, err_count;

  selfcomp_lockstep_checker #(.NCOPY(NC), .XLEN(XL), .TIMEOUT(TO), .CNTW(CW)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .clear(clear),
    .lane_ready(lane_ready), .lane_rd(lane_rd), .busy(busy), .done(done),
    .data_fail(data_fail), .timing_fail(timing_fail), .timeout(timeout),
    .mismatch_mask(mismatch_mask), .missing_mask(missing_mask),
    .stray_ready(stray_ready), .err_sticky(err_sticky),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 g_clk = ~g_clk;

  int total = 0;
  int bad   = 0;

  // Transaction description: t_r[i] = first-ready cycle after launch (0 = never).
  int          t_r[NC];
  logic [XL-1:0] t_d[NC];
  bit          t_midvalid, t_clr_done;

  // Reference model results
  int            exp_end;
  bit            exp_df, exp_tf, exp_to, exp_skew;
  logic [NC-1:0] exp_mm, exp_miss;
  int            m_txn, m_err;
  bit            m_sticky, m_stray;

  // Observed verdict
  int            obs_cyc;
  logic          obs_df, obs_tf, obs_to;
  logic [NC-1:0] obs_mm, obs_miss;

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic model_clear();
    m_txn = 0; m_err = 0; m_sticky = 0; m_stray = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
  endtask

  // Closed-form verdict from the first-ready cycles and the data.
  task automatic model_txn();
    bit seen[NC];
    bit all;
    int mx;
    all = 1; mx = 0;
    for (int i = 0; i < NC; i++) begin
      seen[i] = (t_r[i] >= 1) && (t_r[i] <= TO);
      if (!seen[i]) all = 0;
      else if (t_r[i] > mx) mx = t_r[i];
    end
    exp_end  = all ? mx : TO;
    exp_skew = 0;
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < NC; j++)
        if (seen[i] && seen[j] && t_r[i] != t_r[j]) exp_skew = 1;
    for (int i = 0; i < NC; i++) begin
      exp_miss[i] = !seen[i];
      exp_mm[i]   = (i > 0) && seen[i] && seen[0] && (t_d[i] != t_d[0]);
    end
    exp_df = |exp_mm;
    exp_to = |exp_miss;
    exp_tf = exp_skew | exp_to;
  endtask

  // Drives one transaction, records the verdict and the done cycle (counted
  // from the launch cycle = 0), then steps past the done cycle. With chain=1
  // the next launch is issued in the done cycle.
  task automatic drive_txn(input bit start_now, input bit chain);
    bit got;
    model_txn();
    if (start_now) begin
      valid = 1'b1;
      lane_ready = '0;
      step();
    end
    valid = 1'b0;
    got = 0;
    obs_cyc = 0;
    for (int c = 1; c <= TO + 2 && !got; c++) begin
      valid = t_midvalid && (c == 2);
      for (int i = 0; i < NC; i++) begin
        lane_ready[i] = (t_r[i] == c) ||
                        (t_r[i] != 0 && c > t_r[i] && c <= exp_end && ($urandom_range(0, 1) == 1));
        lane_rd[i*XL +: XL] = (t_r[i] == c) ? t_d[i] : {$urandom, $urandom};
      end
      step();
      if (done === 1'b1) begin
        got = 1;
        obs_cyc  = c + 1;
        obs_df   = data_fail;
        obs_tf   = timing_fail;
        obs_to   = timeout;
        obs_mm   = mismatch_mask;
        obs_miss = missing_mask;
      end
    end
    valid = chain;
    lane_ready = '0;
    clear = t_clr_done;
    step();
    clear = 1'b0;
    valid = 1'b0;
    if (t_clr_done) model_clear();
    m_txn = (m_txn == MAXC) ? MAXC : m_txn + 1;
    if (exp_df || exp_tf) begin
      m_err = (m_err == MAXC) ? MAXC : m_err + 1;
      m_sticky = 1;
    end
  endtask

  task automatic set_all(input int r, input logic [XL-1:0] d);
    for (int i = 0; i < NC; i++) begin t_r[i] = r; t_d[i] = d; end
    t_midvalid = 0; t_clr_done = 0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1; valid = 1'b0; clear = 1'b0; lane_ready = '0; lane_rd = '0;
    step(); step();
    g_reset = 1'b0;
    model_clear();
    total++;
    if ({busy, done, data_fail, timing_fail, timeout, mismatch_mask, missing_mask,
         stray_ready, err_sticky, txn_count, err_count} !== '0) begin
      $display("FAIL reset_outputs got busy=%b done=%b txn=%0d err=%0d want all zero",
               busy, done, txn_count, err_count); bad++;
    end
  endtask

  task automatic test_basic();
    do_clear();
    set_all(1, 64'h0123456789ABCDEF);
    drive_txn(1, 0);
    total++; if (obs_cyc !== 2) begin $display("FAIL basic_done_cycle got=%0d want=2", obs_cyc); bad++; end
    total++; if (obs_df !== 1'b0) begin $display("FAIL basic_data_fail got=%b want=0", obs_df); bad++; end
    total++; if (obs_tf !== 1'b0) begin $display("FAIL basic_timing_fail got=%b want=0", obs_tf); bad++; end
    total++; if (txn_count !== 2'd1) begin $display("FAIL basic_txn_count got=%0d want=1", txn_count); bad++; end
  endtask

  task automatic test_mismatch();
    do_clear();
    set_all(1, 64'hBEEF);
    t_d[2] = 64'hDEAD;
    drive_txn(1, 0);
    total++; if (obs_mm !== 4'b0100) begin $display("FAIL mm_mask got=%b want=0100", obs_mm); bad++; end
    total++; if (obs_df !== 1'b1) begin $display("FAIL mm_data_fail got=%b want=1", obs_df); bad++; end
    total++; if (err_sticky !== 1'b1) begin $display("FAIL mm_err_sticky got=%b want=1", err_sticky); bad++; end
    total++; if (err_count !== 2'd1) begin $display("FAIL mm_err_count got=%0d want=1", err_count); bad++; end
  endtask

  task automatic test_skew();
    do_clear();
    set_all(3, 64'h5555);
    t_r[0] = 1;
    drive_txn(1, 0);
    total++; if (obs_cyc !== 4) begin $display("FAIL skew_done_cycle got=%0d want=4", obs_cyc); bad++; end
    total++; if (obs_tf !== 1'b1) begin $display("FAIL skew_timing_fail got=%b want=1", obs_tf); bad++; end
    total++; if (obs_to !== 1'b0) begin $display("FAIL skew_timeout got=%b want=0", obs_to); bad++; end
    total++; if (obs_df !== 1'b0) begin $display("FAIL skew_data_fail got=%b want=0", obs_df); bad++; end
  endtask

  task automatic test_timeout();
    int extra;
    do_clear();
    set_all(1, 64'h77);
    t_r[1] = 0;
    t_midvalid = 1;
    drive_txn(1, 0);
    t_midvalid = 0;
    total++; if (obs_cyc !== TO + 1) begin $display("FAIL to_done_cycle got=%0d want=%0d", obs_cyc, TO + 1); bad++; end
    total++; if (obs_to !== 1'b1) begin $display("FAIL to_timeout got=%b want=1", obs_to); bad++; end
    total++; if (obs_miss !== 4'b0010) begin $display("FAIL to_missing got=%b want=0010", obs_miss); bad++; end
    total++; if (obs_mm !== 4'b0000) begin $display("FAIL to_mismatch got=%b want=0000", obs_mm); bad++; end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      step();
    end
    total++; if (extra !== 0) begin $display("FAIL to_ignored_valid got=%0d busy/done cycles want=0", extra); bad++; end
    total++; if (txn_count !== 2'd1) begin $display("FAIL to_txn_count got=%0d want=1", txn_count); bad++; end
  endtask

  task automatic test_saturate_clear();
    do_clear();
    set_all(1, 64'h1234);
    t_d[3] = 64'h4321;
    for (int n = 0; n < 5; n++) drive_txn(1, 0);
    total++; if (err_count !== 2'd3) begin $display("FAIL sat_err_count got=%0d want=3", err_count); bad++; end
    total++; if (txn_count !== 2'd3) begin $display("FAIL sat_txn_count got=%0d want=3", txn_count); bad++; end
    t_clr_done = 1;
    drive_txn(1, 0);
    t_clr_done = 0;
    total++; if (err_count !== 2'd1) begin $display("FAIL clr_done_err_count got=%0d want=1", err_count); bad++; end
    total++; if (txn_count !== 2'd1) begin $display("FAIL clr_done_txn_count got=%0d want=1", txn_count); bad++; end
    total++; if (err_sticky !== 1'b1) begin $display("FAIL clr_done_sticky got=%b want=1", err_sticky); bad++; end
  endtask

  task automatic test_back_to_back();
    do_clear();
    set_all(2, 64'hA5A5);
    drive_txn(1, 1);
    total++; if (obs_cyc !== 3) begin $display("FAIL b2b_first_done got=%0d want=3", obs_cyc); bad++; end
    set_all(1, 64'h5A5A);
    drive_txn(0, 0);
    total++; if (obs_cyc !== 2) begin $display("FAIL b2b_second_done got=%0d want=2", obs_cyc); bad++; end
    total++; if (txn_count !== 2'd2) begin $display("FAIL b2b_txn_count got=%0d want=2", txn_count); bad++; end
  endtask

  task automatic test_stray_and_reset();
    int seen_done;
    do_clear();
    total++; if (stray_ready !== 1'b0) begin $display("FAIL stray_initial got=%b want=0", stray_ready); bad++; end
    lane_ready = 4'b0100;
    step();
    lane_ready = '0;
    total++; if (stray_ready !== 1'b1) begin $display("FAIL stray_set got=%b want=1", stray_ready); bad++; end
    set_all(1, 64'h99);
    t_d[1] = 64'h98;
    drive_txn(1, 0);
    valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    total++; if (busy !== 1'b1) begin $display("FAIL midreset_busy_before got=%b want=1", busy); bad++; end
    g_reset = 1'b1;
    step();
    total++;
    if ({busy, done, data_fail, timing_fail, timeout, mismatch_mask, missing_mask,
         stray_ready, err_sticky, txn_count, err_count} !== '0) begin
      $display("FAIL midreset_outputs got busy=%b mm=%b stray=%b sticky=%b txn=%0d err=%0d want all zero",
               busy, mismatch_mask, stray_ready, err_sticky, txn_count, err_count); bad++;
    end
    g_reset = 1'b0;
    model_clear();
    seen_done = 0;
    for (int k = 0; k < TO + 3; k++) begin
      if (done === 1'b1) seen_done++;
      step();
    end
    total++; if (seen_done !== 0) begin $display("FAIL midreset_no_done got=%0d want=0", seen_done); bad++; end
  endtask

  task automatic test_random();
    bit chained, ch;
    logic [XL-1:0] base;
    int c0, sel;
    do_clear();
    chained = 0;
    for (int n = 0; n < 40; n++) begin
      base = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        c0 = $urandom_range(1, TO);
        for (int i = 0; i < NC; i++) t_r[i] = c0;
      end else begin
        for (int i = 0; i < NC; i++) t_r[i] = $urandom_range(0, TO);
      end
      for (int i = 0; i < NC; i++) t_d[i] = base;
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, NC - 1);
        t_d[sel] = base ^ {32'h0, $urandom | 32'h1};
      end
      t_midvalid = ($urandom_range(0, 3) == 0);
      t_clr_done = ($urandom_range(0, 7) == 0);
      ch = (n != 39) && ($urandom_range(0, 1) == 1);
      drive_txn(!chained, ch);
      chained = ch;
      total++;
      if (obs_cyc !== exp_end + 1 || obs_mm !== exp_mm || obs_miss !== exp_miss ||
          obs_df !== exp_df || obs_tf !== exp_tf || obs_to !== exp_to) begin
        $display("FAIL rand_verdict[%0d] got cyc=%0d mm=%b miss=%b df=%b tf=%b to=%b want cyc=%0d mm=%b miss=%b df=%b tf=%b to=%b",
                 n, obs_cyc, obs_mm, obs_miss, obs_df, obs_tf, obs_to,
                 exp_end + 1, exp_mm, exp_miss, exp_df, exp_tf, exp_to); bad++;
      end
      total++;
      if (txn_count !== m_txn[CW-1:0] || err_count !== m_err[CW-1:0] ||
          err_sticky !== m_sticky || stray_ready !== m_stray) begin
        $display("FAIL rand_counters[%0d] got txn=%0d err=%0d sticky=%b stray=%b want txn=%0d err=%0d sticky=%b stray=%b",
                 n, txn_count, err_count, err_sticky, stray_ready, m_txn, m_err, m_sticky, m_stray); bad++;
      end
    end
    t_midvalid = 0; t_clr_done = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_skew();
    test_timeout();
    test_saturate_clear();
    test_back_to_back();
    test_stray_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
